// File: rtl/odbiornik_pkg.sv
// Shared types and constants for the serial-to-parallel receiver.
// Imported by the receiver top and its input shift register.
package odbiornik_pkg;

   typedef enum logic {IDLE, SHIFT} stan_t;

   localparam logic DIR_LSB_FIRST = 1'b0;
   localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/rejestr_wejsciowy.sv
// WIDTH-bit input shift register: LSB-first words enter at the top,
// MSB-first words enter at bit 0.
module rejestr_wejsciowy
   import odbiornik_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             RST,
   input  logic             CLK,
   input  logic             EN,
   input  logic             DIR,
   input  logic             SDI,
   output logic [WIDTH-1:0] D
);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         D <= '0;
      end else if (EN) begin
         if (DIR == DIR_MSB_FIRST) D <= {D[WIDTH-2:0], SDI};
         else                      D <= {SDI, D[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/odbiornik_szeregowy.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words from SDI while SEN is high
// and presents them on a valid/ready output with abort and sticky overrun reporting.
module odbiornik_szeregowy
   import odbiornik_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             SEN,
   input  logic             SDI,
   input  logic             DIR,
   input  logic             READY,
   input  logic             OVR_CLR,
   output logic [WIDTH-1:0] Q,
   output logic             VALID,
   output logic             ABORT,
   output logic             OVR
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   stan_t            state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic             dir_q;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] word_new;
   logic [WIDTH-1:0] q_q;
   logic             valid_q, abort_q, ovr_q;
   logic             first_bit, dir_eff, word_done, abort_set, overrun;

   rejestr_wejsciowy #(
      .WIDTH (WIDTH)
   ) u_rejestr (
      .RST (RST),
      .CLK (CLK),
      .EN  (SEN),
      .DIR (dir_eff),
      .SDI (SDI),
      .D   (sr)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (SEN)  state_d = SHIFT;
         SHIFT: if (!SEN) state_d = IDLE;
      endcase
   end

   always_comb begin
      first_bit = (cnt_q == '0);
      // The first bit of a word must already shift in the freshly latched order.
      dir_eff   = first_bit ? DIR : dir_q;
      word_done = SEN && (cnt_q == LAST);
      abort_set = (state_q == SHIFT) && !SEN && !first_bit;
      overrun   = word_done && valid_q && !READY;
   end

   // Completion never falls on the first bit, so the latched order is valid here.
   assign word_new = (dir_q == DIR_LSB_FIRST) ? {SDI, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], SDI};

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt_q <= '0;
         dir_q <= DIR_LSB_FIRST;
      end else if (SEN) begin
         cnt_q <= word_done ? '0 : cnt_q + CW'(1);
         if (first_bit) dir_q <= DIR;
      end else begin
         cnt_q <= '0;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         q_q     <= '0;
         valid_q <= 1'b0;
         abort_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         abort_q <= abort_set;
         ovr_q   <= (ovr_q && !OVR_CLR) || overrun;
         if (word_done && (!valid_q || READY)) begin
            q_q     <= word_new;
            valid_q <= 1'b1;
         end else if (READY) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign Q     = q_q;
   assign VALID = valid_q;
   assign ABORT = abort_q;
   assign OVR   = ovr_q;

endmodule

// File: tb/tb_odbiornik_szeregowy.sv
// Directed and randomized bench for odbiornik_szeregowy against a bit-queue reference model.
module tb_odbiornik_szeregowy;

   localparam int W = 4;

   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic         SEN = 1'b0;
   logic         SDI = 1'b0;
   logic         DIR = 1'b0;
   logic         READY = 1'b0;
   logic         OVR_CLR = 1'b0;
   logic [W-1:0] Q;
   logic         VALID, ABORT, OVR;

   int checks = 0;
   int passed = 0;

   // Reference model: bits of the word in progress, in arrival order.
   logic         m_bits[$];
   logic         m_dir = 1'b0;
   logic [W-1:0] m_q = '0;
   logic         m_valid = 1'b0;
   logic         m_abort = 1'b0;
   logic         m_ovr = 1'b0;

   always #5 CLK = ~CLK;

   odbiornik_szeregowy #(
      .WIDTH (W)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .SEN     (SEN),
      .SDI     (SDI),
      .DIR     (DIR),
      .READY   (READY),
      .OVR_CLR (OVR_CLR),
      .Q       (Q),
      .VALID   (VALID),
      .ABORT   (ABORT),
      .OVR     (OVR)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   task automatic chk_all(input string tag);
      chk({tag, "_q"}, 32'(Q), 32'(m_q));
      chk({tag, "_valid"}, 32'(VALID), 32'(m_valid));
      chk({tag, "_abort"}, 32'(ABORT), 32'(m_abort));
      chk({tag, "_ovr"}, 32'(OVR), 32'(m_ovr));
   endtask

   task automatic model_edge(input logic sen, input logic sdi, input logic dir,
                             input logic ready, input logic clr);
      logic         done = 1'b0;
      logic         ovr_new = 1'b0;
      logic [W-1:0] w = '0;
      m_abort = 1'b0;
      if (sen) begin
         if (m_bits.size() == 0) m_dir = dir;
         m_bits.push_back(sdi);
         if (m_bits.size() == W) begin
            done = 1'b1;
            for (int i = 0; i < W; i++)
               if (m_bits[i]) w[m_dir ? (W - 1 - i) : i] = 1'b1;
            m_bits.delete();
         end
      end else begin
         if (m_bits.size() != 0) m_abort = 1'b1;
         m_bits.delete();
      end
      if (done && (!m_valid || ready)) begin
         m_q     = w;
         m_valid = 1'b1;
      end else begin
         if (done) ovr_new = 1'b1;
         if (ready) m_valid = 1'b0;
      end
      m_ovr = (m_ovr && !clr) || ovr_new;
   endtask

   task automatic step(input logic sen, input logic sdi, input logic dir, input logic ready,
                       input logic clr, input string tag);
      SEN = sen; SDI = sdi; DIR = dir; READY = ready; OVR_CLR = clr;
      model_edge(sen, sdi, dir, ready, clr);
      @(posedge CLK);
      #1;
      chk_all(tag);
   endtask

   // pat[W-1] is sent first.
   task automatic frame(input logic [W-1:0] pat, input logic dir, input logic ready,
                        input string tag);
      for (int i = W - 1; i >= 0; i--) step(1'b1, pat[i], dir, ready, 1'b0, tag);
   endtask

   task automatic idle(input logic ready, input string tag);
      step(1'b0, 1'b0, 1'b0, ready, 1'b0, tag);
   endtask

   task automatic async_reset(input string tag);
      #2;
      RST = 1'b0; SEN = 1'b0; SDI = 1'b0; DIR = 1'b0; READY = 1'b0; OVR_CLR = 1'b0;
      m_bits.delete();
      m_q = '0; m_valid = 1'b0; m_abort = 1'b0; m_ovr = 1'b0;
      #1;
      chk_all(tag);
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #1;
      chk_all("reset");
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;

      // LSB first, then MSB first, with the same bits 1,0,1,1
      frame(4'b1011, 1'b0, 1'b1, "t1");
      chk("t1_word", 32'(Q), 'hD);
      chk("t1_valid", 32'(VALID), 1);
      idle(1'b1, "t1_idle");
      frame(4'b1011, 1'b1, 1'b1, "t2");
      chk("t2_word", 32'(Q), 'hB);
      idle(1'b1, "t2_idle");

      // Back-to-back words with no gap
      frame(4'b1100, 1'b0, 1'b1, "t3a");
      chk("t3_word_a", 32'(Q), 'h3);
      frame(4'b0101, 1'b0, 1'b1, "t3b");
      chk("t3_word_b", 32'(Q), 'hA);
      idle(1'b1, "t3_idle");

      // Partial frame aborts, then a clean frame
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "t4_bit");
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "t4_bit");
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t4_end");
      chk("t4_abort", 32'(ABORT), 1);
      chk("t4_novalid", 32'(VALID), 0);
      idle(1'b1, "t4_idle");
      chk("t4_abort_gone", 32'(ABORT), 0);
      frame(4'b0110, 1'b0, 1'b1, "t4f");
      chk("t4_word", 32'(Q), 'h6);
      idle(1'b1, "t4_idle2");

      // Overrun: 4'hA held, 4'h5 dropped
      frame(4'b0101, 1'b0, 1'b0, "t5a");
      frame(4'b1010, 1'b0, 1'b0, "t5b");
      chk("t5_word", 32'(Q), 'hA);
      chk("t5_ovr", 32'(OVR), 1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t5_ack");
      chk("t5_valid_clr", 32'(VALID), 0);
      chk("t5_ovr_sticky", 32'(OVR), 1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t5_clr");
      chk("t5_ovr_clr", 32'(OVR), 0);

      // Reset in the middle of a word
      frame(4'b0101, 1'b0, 1'b0, "t6pre");
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t6_bit");
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t6_bit");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t6_bit");
      async_reset("t6_rst");
      frame(4'b1001, 1'b1, 1'b1, "t6f");
      chk("t6_word", 32'(Q), 'h9);
      idle(1'b1, "t6_idle");

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 15) == 0), "rnd");
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/odbiornik_szeregowy.md
Name: odbiornik_szeregowy

Overview:
Serial-to-parallel receiver: the receiving end of the serial link driven by our universal shift register (parallel load, then shift left/right). Samples one bit per clock while the frame enable is high and assembles WIDTH-bit words in either bit order. Presents each completed word on a valid/ready output handshake, with abort and overrun reporting. Sits between the serial pin interface and the parallel datapath.

Parameters:
WIDTH, 4, word length in bits; legal range 2..32.
CW, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
CLK  input  1  system clock; all state changes on the rising edge.
RST  input  1  asynchronous, active-low reset.
SEN  input  1  frame enable; a bit is sampled on every rising edge where SEN=1.
SDI  input  1  serial data in.
DIR  input  1  bit order: 0 = LSB first (shift right), 1 = MSB first (shift left); latched on the first bit of each word.
READY  input  1  consumer accepts Q when READY=1 and VALID=1.
OVR_CLR  input  1  synchronous clear of OVR.
Q  output  WIDTH  last completed word.
VALID  output  1  Q holds an unconsumed word.
ABORT  output  1  one-cycle pulse: frame ended with a partial word.
OVR  output  1  sticky overrun flag.

Behaviour:
- Reset (RST=0, asynchronous): Q=0, VALID=0, ABORT=0, OVR=0, bit counter=0, shift register=0, latched DIR=0, state IDLE. Any word in progress is discarded. Outputs are undefined-free from the first edge after release.
- FSM states: IDLE, SHIFT.
  - IDLE with SEN=1: sample SDI, latch DIR, set counter to 1, go to SHIFT.
  - SHIFT with SEN=1: sample SDI, increment counter.
  - SHIFT with SEN=0 and 0 < counter < WIDTH: ABORT=1 for one cycle, counter=0, partial data dropped, go to IDLE.
- Shift rules:
  - DIR=0: shift right, new bit enters bit [WIDTH-1]; the first bit received ends in Q[0].
  - DIR=1: shift left, new bit enters bit [0]; the first bit received ends in Q[WIDTH-1].
- Completion: the edge that samples bit WIDTH loads Q with the assembled word, including that bit, and sets VALID. Latency is VALID=1 in the cycle after the last bit is presented.
- After completion the counter returns to 0:
  - SEN still 1: stay in SHIFT. The next bit starts a new word with DIR re-latched. Back-to-back words have no gap.
  - SEN=0: go to IDLE. No ABORT is raised, because counter=0.
- Handshake:
  - VALID stays high until an edge with READY=1, then clears.
  - If a word completes on that same edge, Q takes the new word and VALID stays 1.
  - READY while VALID=0 has no effect.
- Overrun: a word completes while VALID=1 and READY=0.
  - The new word is dropped; Q and VALID are unchanged.
  - OVR is set and holds until OVR_CLR=1 or reset.
  - If OVR_CLR and a new overrun occur on the same edge, set wins.
- ABORT and completion are mutually exclusive by construction.

Decomposition:
- Package odbiornik_pkg holds:
  - typedef enum logic {IDLE, SHIFT} stan_t.
  - Constants DIR_LSB_FIRST=1'b0 and DIR_MSB_FIRST=1'b1.
- One sub-module, rejestr_wejsciowy: WIDTH-bit shift register with ports RST, CLK, EN, DIR, SDI, D.
  - Shifts only when EN=1, direction set by DIR.
  - Cleared by asynchronous reset.
- The top module owns the FSM, bit counter, Q/VALID register, ABORT and OVR.

Test Plan:
1. WIDTH=4, DIR=0, SEN=1 for 4 cycles with SDI=1,0,1,1, READY=1 -> Q=4'b1101 and VALID=1 for one cycle after the 4th edge; ABORT=0.
2. Same stimulus with DIR=1 -> Q=4'b1011.
3. SEN=1 for 8 cycles, SDI=1,1,0,0,0,1,0,1, DIR=0, READY=1 -> Q=4'b0011, then Q=4'b1010 exactly 4 cycles later; no gap and no ABORT.
4. SEN=1 for 2 bits then SEN=0 -> ABORT pulses for exactly one cycle, VALID stays 0; the following full frame 0,1,1,0 (DIR=0) gives Q=4'b0110.
5. READY=0 with two back-to-back words 4'hA then 4'h5 -> Q stays 4'hA, VALID=1, OVR=1; READY=1 clears VALID; OVR=1 persists until OVR_CLR=1, then OVR=0.
6. RST=0 asynchronously after 3 bits -> Q=0, VALID=0, OVR=0 immediately; after release a fresh 4-bit frame decodes correctly with no leftover bits.
